// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-access stage.
//   - Pipeline-control codes (cond): COND_FLOW / COND_STALL / COND_ZERO.
//   - IR_NON: bubble instruction loaded on reset/zero. Its opcode (0x3F) is
//     unused, so it decodes as a non-memory op.
//   - MIPS load/store opcodes.
//   - Memory-op kind enum, FSM state enum and the decode helpers.
package mem_access_pkg;

  localparam logic [1:0]  COND_FLOW  = 2'b00;
  localparam logic [1:0]  COND_STALL = 2'b01;
  localparam logic [1:0]  COND_ZERO  = 2'b10;

  localparam logic [31:0] IR_NON     = 32'hFC00_0000;

  localparam logic [5:0]  OP_LB  = 6'h20;
  localparam logic [5:0]  OP_LH  = 6'h21;
  localparam logic [5:0]  OP_LW  = 6'h23;
  localparam logic [5:0]  OP_LBU = 6'h24;
  localparam logic [5:0]  OP_LHU = 6'h25;
  localparam logic [5:0]  OP_SB  = 6'h28;
  localparam logic [5:0]  OP_SH  = 6'h29;
  localparam logic [5:0]  OP_SW  = 6'h2B;

  typedef enum logic [3:0] {
    MOP_NONE,
    MOP_LB,
    MOP_LBU,
    MOP_LH,
    MOP_LHU,
    MOP_LW,
    MOP_SB,
    MOP_SH,
    MOP_SW
  } mop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic mop_e decode_mop(input logic [5:0] opcode);
    mop_e m;
    case (opcode)
      OP_LB:   m = MOP_LB;
      OP_LBU:  m = MOP_LBU;
      OP_LH:   m = MOP_LH;
      OP_LHU:  m = MOP_LHU;
      OP_LW:   m = MOP_LW;
      OP_SB:   m = MOP_SB;
      OP_SH:   m = MOP_SH;
      OP_SW:   m = MOP_SW;
      default: m = MOP_NONE;
    endcase
    return m;
  endfunction

  function automatic logic mop_is_load(input mop_e m);
    return (m == MOP_LB) || (m == MOP_LBU) || (m == MOP_LH) ||
           (m == MOP_LHU) || (m == MOP_LW);
  endfunction

  function automatic logic mop_is_store(input mop_e m);
    return (m == MOP_SB) || (m == MOP_SH) || (m == MOP_SW);
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// load_extend: combinational little-endian lane select and sign/zero
// extension of load data.
// Ports:
//   rdata   in  32 : raw word returned by the data memory
//   addr_lo in  2  : low byte-address bits (lane select)
//   op      in     : memory-op kind (non-loads produce the raw word)
//   data    out 32 : extended load value
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mop_e        op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MOP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MOP_LBU: data = {24'd0, byte_sel};
      MOP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MOP_LHU: data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage. Issues load/store transactions
// on the data-memory req/ack port, extracts load data, and registers the
// stage result for write-back under the shared cond pipeline control.
// Optional build macro: MEM_ALIGN_CHECK_EN (suppress misaligned accesses and
// raise misalign); when undefined misalign is tied to 0.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ex_Z/ex_Rt/ex_IR/ex_HI/ex_LO : execute-stage registered results
//   cond                         : FLOW / STALL / ZERO pipeline control
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata : data-memory request side
//   dm_rdata/dm_ack              : data-memory response side
//   rZ/rMD/rHI/rLO/rIR           : registered stage result
//   stallForMem                  : stall request while a transaction is open
//   misalign                     : misaligned-access flag
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_Z,
  input  logic [31:0] ex_Rt,
  input  logic [31:0] ex_IR,
  input  logic [31:0] ex_HI,
  input  logic [31:0] ex_LO,
  input  logic [1:0]  cond,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] rZ,
  output logic [31:0] rMD,
  output logic [31:0] rHI,
  output logic [31:0] rLO,
  output logic [31:0] rIR,
  output logic        stallForMem,
  output logic        misalign
);

  mop_e        mop;
  logic        is_ld;
  logic        is_st;
  logic        mis;
  logic        act;
  logic [31:0] ext_data;

  state_e      state_q, state_d;
  logic [31:0] md_buf_q, md_buf_d;
  logic [31:0] rz_q, rmd_q, rhi_q, rlo_q, rir_q;

  assign mop   = decode_mop(ex_IR[31:26]);
  assign is_ld = mop_is_load(mop);
  assign is_st = mop_is_store(mop);

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    case (mop)
      MOP_LW, MOP_SW:          mis = (ex_Z[1:0] != 2'b00);
      MOP_LH, MOP_LHU, MOP_SH: mis = ex_Z[0];
      default:                 mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign misalign = mis;
  // A suppressed (misaligned) access behaves like a non-memory op.
  assign act      = (is_ld | is_st) & ~mis;

  load_extend u_load_extend (
    .rdata   (dm_rdata),
    .addr_lo (ex_Z[1:0]),
    .op      (mop),
    .data    (ext_data)
  );

  // Handshake FSM: IDLE issues, BUSY waits for ack, DONE parks until FLOW.
  always_comb begin
    state_d  = state_q;
    md_buf_d = md_buf_q;
    dm_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (act) begin
          dm_req = 1'b1;
          if (dm_ack) begin
            state_d  = ST_DONE;
            md_buf_d = ext_data;
          end else begin
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        dm_req = 1'b1;
        if (dm_ack) begin
          state_d  = ST_DONE;
          md_buf_d = ext_data;
        end
      end
      ST_DONE: begin
        if (cond == COND_FLOW) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // ZERO squashes the stage: an un-acked request is abandoned.
    if (cond == COND_ZERO) state_d = ST_IDLE;
  end

  assign stallForMem = act & (state_q != ST_DONE);

  // Request side is purely combinational from the execute registers, which
  // the controller holds while we stall, so it stays stable until ack.
  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = ex_Rt;
    case (mop)
      MOP_SH: begin
        dm_be    = ex_Z[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{ex_Rt[15:0]}};
      end
      MOP_SB: begin
        dm_be    = 4'b0001 << ex_Z[1:0];
        dm_wdata = {4{ex_Rt[7:0]}};
      end
      default: ;
    endcase
  end

  assign dm_we   = dm_req & is_st;
  assign dm_addr = {ex_Z[31:2], 2'b00};

  // Stage result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      md_buf_q <= 32'd0;
      rz_q     <= 32'd0;
      rmd_q    <= 32'd0;
      rhi_q    <= 32'd0;
      rlo_q    <= 32'd0;
      rir_q    <= IR_NON;
    end else begin
      state_q  <= state_d;
      md_buf_q <= md_buf_d;
      case (cond)
        COND_FLOW: begin
          rz_q  <= ex_Z;
          rmd_q <= (is_ld & ~mis) ? md_buf_q : 32'd0;
          rhi_q <= ex_HI;
          rlo_q <= ex_LO;
          rir_q <= ex_IR;
        end
        COND_ZERO: begin
          rz_q  <= 32'd0;
          rmd_q <= 32'd0;
          rhi_q <= 32'd0;
          rlo_q <= 32'd0;
          rir_q <= IR_NON;
        end
        default: ;
      endcase
    end
  end

  assign rZ  = rz_q;
  assign rMD = rmd_q;
  assign rHI = rhi_q;
  assign rLO = rlo_q;
  assign rIR = rir_q;

endmodule
